buzzer_arbiter: RTL

Shares the single buzzer note input between several note sources, such as free play, auto play, learn mode and record playback. Each source raises a request and drives a 5-bit note code; the arbiter picks one owner by fixed priority, inserts a silent gap on every ownership change, and drives the buzzer's note input. Sits between the mode-specific players and the one buzzer instance in the top level.

---
 rtl/buzzer_arbiter_pkg.sv | 26 ++
 rtl/buzzer_arbiter_if.sv | 21 ++
 rtl/buzzer_arbiter_prio_pick.sv | 33 +++
 rtl/buzzer_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/buzzer_arbiter_pkg.sv
// Shared constants and types for the buzzer arbiter.
// CLK_FREQ sets the default ownership-change gap (CLK_FREQ/100 cycles).
// Requester indices name the sources; index 0 has the highest priority.
package buzzer_arbiter_pkg;

    localparam int unsigned CLK_FREQ  = 50_000_000;
    localparam int unsigned BA_NOTE_W = 5;
    localparam logic [BA_NOTE_W-1:0] NOTE_REST = '0;

    localparam int unsigned REQ_FREE  = 0;
    localparam int unsigned REQ_LEARN = 1;
    localparam int unsigned REQ_AUTO  = 2;
    localparam int unsigned REQ_REC   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_OWN  = 2'd2
    } state_e;

    // Index width that stays at least one bit for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/buzzer_arbiter_if.sv
// Note-source to buzzer bus.
//   req      per-source request (level)
//   note_in  flattened note codes, source i at [i*NOTE_W +: NOTE_W]
//   mute     global silence
//   grant    one-hot owner
//   note_out note code to the buzzer
//   busy     arbiter is in a gap or owned
interface buzzer_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned NOTE_W  = 5
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*NOTE_W-1:0] note_in;
    logic                      mute;
    logic [NUM_REQ-1:0]        grant;
    logic [NOTE_W-1:0]         note_out;
    logic                      busy;

    modport master (output req, note_in, mute, input grant, note_out, busy);
    modport slave  (input req, note_in, mute, output grant, note_out, busy);
endinterface

// File: rtl/buzzer_arbiter_prio_pick.sv
// Fixed-priority picker: lowest-index asserted request wins.
//   req       request vector
//   pick_oh_c one-hot winner (zero when no request)
//   pick_idx_c binary index of the winner (zero when no request)
//   any_c     at least one request is asserted
module buzzer_arbiter_prio_pick
    import buzzer_arbiter_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     pick_oh_c,
    output logic [IDX_W-1:0] pick_idx_c,
    output logic             any_c
);

    // Scan from the top down so the lowest set index is the last write.
    always_comb begin
        pick_oh_c  = '0;
        pick_idx_c = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_oh_c    = '0;
                pick_oh_c[i] = 1'b1;
                pick_idx_c   = IDX_W'(i);
            end
        end
    end

    assign any_c = |req;

endmodule

// File: rtl/buzzer_arbiter.sv
// Buzzer arbiter: shares one buzzer note input between prioritized sources,
// inserting GAP_CYC silent cycles on every ownership change.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         buzzer_arbiter_if slave (req/note_in/mute in, grant/note_out/busy out)
// Optional macro PREEMPT_EN: a higher-priority request preempts the owner.
module buzzer_arbiter
    import buzzer_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned NOTE_W  = BA_NOTE_W,
    parameter int unsigned GAP_CYC = CLK_FREQ / 100
) (
    input  logic             clk,
    input  logic             rst_n,
    buzzer_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(GAP_CYC + 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);

    if (GAP_CYC == 0) begin : g_bad_gap
        $error("buzzer_arbiter: GAP_CYC must be at least 1");
    end

    state_e             state;
    logic [IDX_W-1:0]   cand;
    logic [NUM_REQ-1:0] cand_oh;
    logic [CNT_W-1:0]   gap_cnt;

    logic [NUM_REQ-1:0] pick_oh_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic               any_c;
    logic               cand_req_c;
    logic [NOTE_W-1:0]  notes [NUM_REQ];
    logic [NOTE_W-1:0]  owner_note_c;

    buzzer_arbiter_prio_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (bus.req),
        .pick_oh_c  (pick_oh_c),
        .pick_idx_c (pick_idx_c),
        .any_c      (any_c)
    );

    // Unflatten note codes so the owner's note is a plain array lookup.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_notes
        assign notes[g] = bus.note_in[g*NOTE_W +: NOTE_W];
    end

    assign owner_note_c = notes[cand];
    assign cand_req_c   = |(bus.req & cand_oh);

    // Arbiter FSM with registered grant/note_out/busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cand         <= '0;
            cand_oh      <= '0;
            gap_cnt      <= '0;
            bus.grant    <= '0;
            bus.note_out <= '0;
            bus.busy     <= 1'b0;
        end else begin
            // Silent unless the owner keeps the buzzer and mute is low.
            bus.note_out <= NOTE_W'(NOTE_REST);
            case (state)
                ST_IDLE: begin
                    if (any_c) begin
                        state    <= ST_GAP;
                        cand     <= pick_idx_c;
                        cand_oh  <= pick_oh_c;
                        gap_cnt  <= GAP_LOAD;
                        bus.busy <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (!cand_req_c) begin
                        if (any_c) begin
                            cand    <= pick_idx_c;
                            cand_oh <= pick_oh_c;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state    <= ST_IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else if (gap_cnt == '0) begin
                        state     <= ST_OWN;
                        bus.grant <= cand_oh;
                    end else begin
                        gap_cnt <= gap_cnt - CNT_W'(1);
                    end
                end
                ST_OWN: begin
                    if (!cand_req_c) begin
                        bus.grant <= '0;
                        if (any_c) begin
                            state   <= ST_GAP;
                            cand    <= pick_idx_c;
                            cand_oh <= pick_oh_c;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state    <= ST_IDLE;
                            bus.busy <= 1'b0;
                        end
                    end
`ifdef PREEMPT_EN
                    // Owner still requests, so the pick is below it only if a
                    // higher-priority source is asking.
                    else if (pick_idx_c < cand) begin
                        bus.grant <= '0;
                        state     <= ST_GAP;
                        cand      <= pick_idx_c;
                        cand_oh   <= pick_oh_c;
                        gap_cnt   <= GAP_LOAD;
                    end
`endif
                    else if (!bus.mute) begin
                        bus.note_out <= owner_note_c;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    bus.grant <= '0;
                    bus.busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
